dart_round_ctrl: RTL and testbench
==================================

DART_ROUND_CTRL -- requirements
Module: dart_round_ctrl

Interface
REQ-001 SHALL have parameter ROUNDS, default 3, legal range 1..9: the number of throws each player makes per game.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: begin a new game; honoured only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: cancel the game in progress.
REQ-006 SHALL have port throw_valid, input, 1 bit: a throw is presented on throw_x/throw_y.
REQ-007 SHALL have port throw_x, input, 4 bits: throw x coordinate, unsigned.
REQ-008 SHALL have port throw_y, input, 4 bits: throw y coordinate, unsigned.
REQ-009 SHALL have port throw_ready, output, 1 bit: the block can accept a throw.
REQ-010 SHALL have port score_x, output, 4 bits: registered coordinate driven to the shared external region scorer.
REQ-011 SHALL have port score_y, output, 4 bits: registered coordinate driven to the shared external region scorer.
REQ-012 SHALL have port score_in, input, 3 bits: region score 0..7 returned combinationally by the scorer.
REQ-013 SHALL have port cur_player, output, 2 bits: player whose throw is expected (0=A .. 3=D).
REQ-014 SHALL have port cur_round, output, 4 bits: current round, 0-based.
REQ-015 SHALL have ports total_a, total_b, total_c and total_d, output, 6 bits each: accumulated score per player.
REQ-016 SHALL have port winner, output, 2 bits: index of the winning player.
REQ-017 SHALL have port winner_score, output, 6 bits: the winning player's total.
REQ-018 SHALL have port tie, output, 1 bit: another player's total equals winner_score.
REQ-019 SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-020 SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.

Function
REQ-021 SHALL implement the states IDLE, WAIT, SCORE, SCAN and DONE.
REQ-022 IDLE: start=1 SHALL clear all totals, cur_round and cur_player, clear winner, winner_score and tie, and go to WAIT.
REQ-023 WAIT: throw_ready=1; on throw_valid&throw_ready SHALL register throw_x/throw_y into score_x/score_y and go to SCORE; throw_ready=0 in every other state.
REQ-024 SCORE (one cycle): SHALL add score_in, zero-extended, to the total of cur_player; score 0 still counts as a throw.
REQ-025 SCORE, next position: cur_player<3 SHALL give player+1 and go to WAIT.
REQ-026 SCORE, next position: cur_player=3 with cur_round<ROUNDS-1 SHALL give player 0, round+1, and go to WAIT.
REQ-027 SCORE, next position: otherwise SHALL go to SCAN.
REQ-028 Throw throughput SHALL be at most one accepted throw per 2 cycles; the score is added on the edge after acceptance.
REQ-029 SCAN SHALL take 4 cycles examining players 0,1,2,3 in order, holding a running maximum.
REQ-030 SCAN: a strictly greater total SHALL replace winner and winner_score and clear tie.
REQ-031 SCAN: an equal total SHALL set tie and keep the lower index.
REQ-032 SCAN: player 0 SHALL initialise the running maximum.
REQ-033 SCAN SHALL then go to DONE.
REQ-034 DONE SHALL assert done for exactly one cycle and go to IDLE; totals, winner, winner_score and tie SHALL hold until the next accepted start.
REQ-035 abort=1 in any non-IDLE state SHALL go to IDLE on the next edge without a done pulse; totals SHALL hold their partial values, and the winner outputs SHALL hold their cleared values.
REQ-036 abort SHALL take priority over every other transition, including a throw in the same cycle, which is then not accepted.
REQ-037 start outside IDLE SHALL be ignored; start and abort together in IDLE SHALL mean start.
REQ-038 Totals SHALL NOT saturate or wrap: the maximum is 7*9=63, which fits in 6 bits.
REQ-039 throw_valid outside WAIT SHALL be ignored; the source holds valid until ready.

Reset
REQ-040 rst_n=0 SHALL asynchronously force IDLE and drive 0 on throw_ready, busy, done, cur_player, cur_round, score_x, score_y, all totals, winner, winner_score and tie.
REQ-041 Release of reset SHALL be synchronous to clk; the first start is accepted on the first edge with rst_n=1.
REQ-042 Reset mid-game SHALL discard all progress and SHALL NOT produce a done pulse.

Verification
REQ-043 Full game, ROUNDS=3, bench scorer returns 7,3,5,1 for A..D each round -> totals 21,9,15,3; winner=0; winner_score=21; tie=0; one done pulse 4 cycles after the last SCORE cycle.
REQ-044 Tie: per-round scores 2,6,6,0, ROUNDS=1 -> winner=1; winner_score=6; tie=1.
REQ-045 Handshake: throw_valid held high continuously -> acceptances exactly every 2 cycles; score_x/score_y equal the accepted coordinates during each SCORE cycle; 12 acceptances for ROUNDS=3.
REQ-046 Abort on round 1 player C together with throw_valid -> throw not accepted; IDLE next cycle; no done; totals show round-0 values plus round-1 A and B.
REQ-047 rst_n low during SCAN -> all outputs 0 immediately; no done; a subsequent start runs a clean game.
REQ-048 ROUNDS=9, all scores 7 -> all totals 63 with no wrap; winner=0; tie=1.

Source files
------------

// File: rtl/dart_round_ctrl.sv
// dart_round_ctrl: sequences four players' throws over ROUNDS rounds,
// accumulates totals via an external scorer, then scans for the winner.
module dart_round_ctrl #(
    parameter int ROUNDS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       throw_valid,
    input  logic [3:0] throw_x,
    input  logic [3:0] throw_y,
    output logic       throw_ready,
    output logic [3:0] score_x,
    output logic [3:0] score_y,
    input  logic [2:0] score_in,
    output logic [1:0] cur_player,
    output logic [3:0] cur_round,
    output logic [5:0] total_a,
    output logic [5:0] total_b,
    output logic [5:0] total_c,
    output logic [5:0] total_d,
    output logic [1:0] winner,
    output logic [5:0] winner_score,
    output logic       tie,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SCORE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [5:0] tot [4];
    logic [1:0] scan_idx;
    logic [5:0] scan_val;
    logic       accept;
    logic       last_throw;
    logic       new_game;

    assign new_game    = (state == S_IDLE) && start;
    assign accept      = (state == S_WAIT) && throw_valid && !abort;
    assign last_throw  = (cur_player == 2'd3) && (cur_round == LAST_ROUND);
    assign scan_val    = tot[scan_idx];

    assign throw_ready = (state == S_WAIT);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    assign total_a     = tot[0];
    assign total_b     = tot[1];
    assign total_c     = tot[2];
    assign total_d     = tot[3];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; abort outranks every other transition.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (abort)            state_nx = S_IDLE;
                else if (throw_valid) state_nx = S_SCORE;
            end
            S_SCORE: begin
                if (abort)           state_nx = S_IDLE;
                else if (last_throw) state_nx = S_SCAN;
                else                 state_nx = S_WAIT;
            end
            S_SCAN: begin
                if (abort)                  state_nx = S_IDLE;
                else if (scan_idx == 2'd3)  state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Capture the accepted throw for the external scorer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_x <= '0;
            score_y <= '0;
        end else if (accept) begin
            score_x <= throw_x;
            score_y <= throw_y;
        end
    end

    // Totals and throw position; an aborted SCORE cycle adds nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) tot[i] <= '0;
            cur_player <= '0;
            cur_round  <= '0;
        end else if (new_game) begin
            for (int i = 0; i < 4; i++) tot[i] <= '0;
            cur_player <= '0;
            cur_round  <= '0;
        end else if ((state == S_SCORE) && !abort) begin
            tot[cur_player] <= tot[cur_player] + {3'b000, score_in};
            if (cur_player != 2'd3) begin
                cur_player <= cur_player + 2'd1;
            end else if (cur_round != LAST_ROUND) begin
                cur_player <= '0;
                cur_round  <= cur_round + 4'd1;
            end
        end
    end

    // Running-maximum scan; equal totals keep the lower index and flag a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_idx     <= '0;
            winner       <= '0;
            winner_score <= '0;
            tie          <= 1'b0;
        end else if (new_game || ((state == S_SCAN) && abort)) begin
            scan_idx     <= '0;
            winner       <= '0;
            winner_score <= '0;
            tie          <= 1'b0;
        end else if (state == S_SCAN) begin
            scan_idx <= scan_idx + 2'd1;
            priority case (1'b1)
                (scan_idx == 2'd0): begin
                    winner       <= '0;
                    winner_score <= scan_val;
                    tie          <= 1'b0;
                end
                (scan_val > winner_score): begin
                    winner       <= scan_idx;
                    winner_score <= scan_val;
                    tie          <= 1'b0;
                end
                (scan_val == winner_score): begin
                    tie <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dart_round_ctrl.sv
// tb_dart_round_ctrl: three instances (ROUNDS 3, 1, 9) share stimulus and
// are compared every cycle against a game-level model kept in the bench.
module tb_dart_round_ctrl;

    localparam int NI = 3;

    function automatic int rounds_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 1 : 9);
    endfunction

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       throw_valid = 1'b0;
    logic [3:0] throw_x = '0;
    logic [3:0] throw_y = '0;

    logic       ready [NI];
    logic       busy  [NI];
    logic       done  [NI];
    logic       tie   [NI];
    logic [3:0] sx    [NI];
    logic [3:0] sy    [NI];
    logic [3:0] rnd   [NI];
    logic [1:0] plr   [NI];
    logic [1:0] win   [NI];
    logic [5:0] ta    [NI];
    logic [5:0] tb_   [NI];
    logic [5:0] tc    [NI];
    logic [5:0] td    [NI];
    logic [5:0] ws    [NI];
    logic [2:0] sin   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign sin[g] = 3'(sx[g] + sy[g]);
        dart_round_ctrl #(.ROUNDS(rounds_of(g))) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start        (start),
            .abort        (abort),
            .throw_valid  (throw_valid),
            .throw_x      (throw_x),
            .throw_y      (throw_y),
            .throw_ready  (ready[g]),
            .score_x      (sx[g]),
            .score_y      (sy[g]),
            .score_in     (sin[g]),
            .cur_player   (plr[g]),
            .cur_round    (rnd[g]),
            .total_a      (ta[g]),
            .total_b      (tb_[g]),
            .total_c      (tc[g]),
            .total_d      (td[g]),
            .winner       (win[g]),
            .winner_score (ws[g]),
            .tie          (tie[g]),
            .busy         (busy[g]),
            .done         (done[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // model: 0 idle, 1 awaiting throw, 2 scoring, 3 scanning, 4 results
    int m_mode [NI];
    int m_scan [NI];
    int m_p    [NI];
    int m_r    [NI];
    int m_tot  [NI][4];
    int m_win  [NI];
    int m_ws   [NI];
    int m_tie  [NI];
    int m_sx   [NI];
    int m_sy   [NI];

    task automatic m_results(input int k);
        int mx;
        int cnt;
        mx = 0;
        for (int i = 0; i < 4; i++) if (m_tot[k][i] > mx) mx = m_tot[k][i];
        cnt = 0;
        m_win[k] = -1;
        for (int i = 0; i < 4; i++) begin
            if (m_tot[k][i] == mx) begin
                cnt++;
                if (m_win[k] < 0) m_win[k] = i;
            end
        end
        m_ws[k]  = mx;
        m_tie[k] = (cnt > 1) ? 1 : 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                m_mode[k] = 0; m_scan[k] = 0; m_p[k] = 0; m_r[k] = 0;
                m_win[k] = 0; m_ws[k] = 0; m_tie[k] = 0;
                m_sx[k] = 0; m_sy[k] = 0;
                for (int i = 0; i < 4; i++) m_tot[k][i] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < NI; k++) begin
                if (m_mode[k] == 0) begin
                    if (start) begin
                        for (int i = 0; i < 4; i++) m_tot[k][i] = 0;
                        m_p[k] = 0; m_r[k] = 0;
                        m_win[k] = 0; m_ws[k] = 0; m_tie[k] = 0;
                        m_mode[k] = 1;
                    end
                end else if (abort) begin
                    if (m_mode[k] != 4) begin
                        m_win[k] = 0; m_ws[k] = 0; m_tie[k] = 0;
                    end
                    m_mode[k] = 0;
                end else begin
                    case (m_mode[k])
                        1: if (throw_valid) begin
                            m_sx[k] = int'(throw_x);
                            m_sy[k] = int'(throw_y);
                            m_mode[k] = 2;
                        end
                        2: begin
                            m_tot[k][m_p[k]] += (m_sx[k] + m_sy[k]) % 8;
                            if (m_p[k] < 3) begin
                                m_p[k]++;
                                m_mode[k] = 1;
                            end else if (m_r[k] < rounds_of(k) - 1) begin
                                m_p[k] = 0;
                                m_r[k]++;
                                m_mode[k] = 1;
                            end else begin
                                m_mode[k] = 3;
                                m_scan[k] = 4;
                            end
                        end
                        3: begin
                            m_scan[k]--;
                            if (m_scan[k] == 0) begin
                                m_results(k);
                                m_mode[k] = 4;
                            end
                        end
                        default: m_mode[k] = 0;
                    endcase
                end
            end
        end
    end

    int acc_n = 0;
    int last_acc = 0;
    int bad_gap = 0;
    int done_n0 = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("u%0d_ready", k), int'(ready[k]), int'(m_mode[k] == 1));
            chk($sformatf("u%0d_busy", k), int'(busy[k]), int'(m_mode[k] != 0));
            chk($sformatf("u%0d_done", k), int'(done[k]), int'(m_mode[k] == 4));
            chk($sformatf("u%0d_player", k), int'(plr[k]), m_p[k]);
            chk($sformatf("u%0d_round", k), int'(rnd[k]), m_r[k]);
            chk($sformatf("u%0d_score_x", k), int'(sx[k]), m_sx[k]);
            chk($sformatf("u%0d_score_y", k), int'(sy[k]), m_sy[k]);
            chk($sformatf("u%0d_total_a", k), int'(ta[k]), m_tot[k][0]);
            chk($sformatf("u%0d_total_b", k), int'(tb_[k]), m_tot[k][1]);
            chk($sformatf("u%0d_total_c", k), int'(tc[k]), m_tot[k][2]);
            chk($sformatf("u%0d_total_d", k), int'(td[k]), m_tot[k][3]);
            if (m_mode[k] != 3) begin
                chk($sformatf("u%0d_winner", k), int'(win[k]), m_win[k]);
                chk($sformatf("u%0d_wscore", k), int'(ws[k]), m_ws[k]);
                chk($sformatf("u%0d_tie", k), int'(tie[k]), m_tie[k]);
            end
        end
        if (rst_n && ready[0] && throw_valid && !abort) begin
            if (acc_n > 0 && (cyc - last_acc) != 2) bad_gap++;
            acc_n++;
            last_acc = cyc;
        end
        if (done[0]) begin
            done_n0++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: full game, 1: abort at round 1 player C, 2: reset during SCAN
    task automatic run_game(input int s0, input int s1, input int s2,
                            input int s3, input int mode);
        int  budget;
        bit  fin;
        acc_n = 0;
        bad_gap = 0;
        done_n0 = 0;
        throw_y = '0;
        throw_x = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        throw_valid = 1'b1;
        budget = 0;
        fin = 1'b0;
        while (!fin) begin
            case (plr[2])
                2'd0: throw_x = 4'(s0);
                2'd1: throw_x = 4'(s1);
                2'd2: throw_x = 4'(s2);
                default: throw_x = 4'(s3);
            endcase
            if (mode == 1 && ready[0] && rnd[0] == 4'd1 && plr[0] == 2'd2) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                fin = 1'b1;
            end else if (mode == 2 && acc_n == 12 && !ready[0] && busy[0]) begin
                tick();
                tick();
                rst_n = 1'b0;
                #1;
                chk("rst_busy", int'(busy[0]), 0);
                chk("rst_done", int'(done[0]), 0);
                chk("rst_total_a", int'(ta[0]), 0);
                chk("rst_score_x", int'(sx[0]), 0);
                chk("rst_winner_score", int'(ws[0]), 0);
                chk("rst_player_round", int'(plr[0]) + int'(rnd[0]), 0);
                fin = 1'b1;
            end else begin
                tick();
                budget++;
                if (!busy[2]) fin = 1'b1;
                if (budget > 400) begin
                    chk("game_timeout", budget, 0);
                    fin = 1'b1;
                end
            end
        end
        throw_valid = 1'b0;
        throw_x = '0;
        abort = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_busy", int'(busy[0]), 0);
        chk("reset_total_a", int'(ta[0]), 0);
        rst_n = 1'b1;

        run_game(7, 3, 5, 1, 0);
        chk("g1_total_a", int'(ta[0]), 21);
        chk("g1_total_b", int'(tb_[0]), 9);
        chk("g1_total_c", int'(tc[0]), 15);
        chk("g1_total_d", int'(td[0]), 3);
        chk("g1_winner", int'(win[0]), 0);
        chk("g1_wscore", int'(ws[0]), 21);
        chk("g1_tie", int'(tie[0]), 0);
        chk("g1_accepts", acc_n, 12);
        chk("g1_accept_gap", bad_gap, 0);
        chk("g1_done_pulses", done_n0, 1);
        chk("g1_done_latency", done_cyc - last_acc, 6);
        tick();

        run_game(2, 6, 6, 0, 0);
        chk("g2_r1_winner", int'(win[1]), 1);
        chk("g2_r1_wscore", int'(ws[1]), 6);
        chk("g2_r1_tie", int'(tie[1]), 1);
        chk("g2_r3_wscore", int'(ws[0]), 18);
        tick();

        run_game(7, 7, 7, 7, 0);
        chk("g3_total_a", int'(ta[2]), 63);
        chk("g3_total_d", int'(td[2]), 63);
        chk("g3_winner", int'(win[2]), 0);
        chk("g3_wscore", int'(ws[2]), 63);
        chk("g3_tie", int'(tie[2]), 1);
        tick();

        run_game(7, 3, 5, 1, 1);
        chk("g4_busy", int'(busy[0]), 0);
        chk("g4_total_a", int'(ta[0]), 14);
        chk("g4_total_b", int'(tb_[0]), 6);
        chk("g4_total_c", int'(tc[0]), 5);
        chk("g4_total_d", int'(td[0]), 1);
        chk("g4_done_pulses", done_n0, 0);
        tick();

        run_game(7, 3, 5, 1, 2);
        tick();
        tick();
        chk("g5_done_pulses", done_n0, 0);
        rst_n = 1'b1;
        tick();

        run_game(7, 3, 5, 1, 0);
        chk("g6_total_a", int'(ta[0]), 21);
        chk("g6_done_pulses", done_n0, 1);
        tick();

        for (int i = 0; i < 6000; i++) begin
            tick();
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            start       = ($urandom_range(0, 7) == 0);
            abort       = ($urandom_range(0, 199) == 0);
            throw_valid = ($urandom_range(0, 3) != 0);
            throw_x     = 4'($urandom_range(0, 15));
            throw_y     = 4'($urandom_range(0, 15));
        end
        start = 1'b0;
        abort = 1'b0;
        throw_valid = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
